// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU/accelerator memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, XFER, RESP} arb_state_t;
    typedef enum logic {OWN_CPU, OWN_ACC} arb_owner_t;

    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational 2-way round-robin pick; zero latency, no backpressure of its own.
// The output is only meaningful when at least one request is present.
module mem_arb_rr_pick (
    input  logic c_req,
    input  logic a_req,
    input  logic last,
    output logic grant
);
    import mem_arb_pkg::*;

    always_comb begin
        grant = logic'(OWN_ACC);
        // The CPU wins when alone, or on a tie if the accelerator went last.
        if (c_req && (!a_req || last == logic'(OWN_ACC))) begin
            grant = logic'(OWN_CPU);
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between CPU and accelerator; grant->mem_cs 1 cycle, mem_valid->x_valid 1 cycle.
// Losing/late requests wait while busy; build with MEM_ARB_TIMEOUT_EN to add the XFER watchdog.
module mem_bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                c_cs,
    input  logic                c_rd_wr,
    input  logic [DATA_W/8-1:0] c_mask,
    input  logic [ADDR_W-1:0]   c_addr,
    input  logic [DATA_W-1:0]   c_wdata,
    output logic [DATA_W-1:0]   c_rdata,
    output logic                c_valid,
    output logic                c_err,

    input  logic                a_cs,
    input  logic                a_rd_wr,
    input  logic [DATA_W/8-1:0] a_mask,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_wdata,
    output logic [DATA_W-1:0]   a_rdata,
    output logic                a_valid,
    output logic                a_err,

    output logic                mem_cs,
    output logic                mem_rd_wr,
    output logic [DATA_W/8-1:0] mem_mask,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_valid,

    output logic                owner
);
    import mem_arb_pkg::*;

    arb_state_t        state;
    arb_state_t        state_nxt;
    arb_owner_t        last_owner;
    arb_owner_t        owner_q;
    logic              grant;
    logic              req_any;
    logic              start;
    logic              finish;
    logic              tmo_hit;
    logic [DATA_W-1:0] rdata_q;

    assign req_any = c_cs | a_cs;
    assign start   = (state == IDLE) && req_any;
    assign finish  = (state == XFER) && (mem_valid || tmo_hit);

    mem_arb_rr_pick u_pick (
        .c_req (c_cs),
        .a_req (a_cs),
        .last  (last_owner),
        .grant (grant)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (start) begin
            tmo_cnt <= '0;
        end else if (state == XFER) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // A completion arriving on the limit cycle takes priority over the timeout.
    assign tmo_hit = (state == XFER) && !mem_valid &&
                     (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (finish) begin
            err_q <= tmo_hit;
        end
    end

    assign c_err = c_valid & err_q;
    assign a_err = a_valid & err_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign tmo_hit = 1'b0;
    assign c_err   = 1'b0;
    assign a_err   = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_any) state_nxt = XFER;
            XFER:    if (mem_valid || tmo_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner <= OWN_ACC;
            owner_q    <= OWN_CPU;
            mem_cs     <= 1'b0;
            mem_rd_wr  <= 1'b0;
            mem_mask   <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata_q    <= '0;
        end else if (start) begin
            last_owner <= arb_owner_t'(grant);
            owner_q    <= arb_owner_t'(grant);
            mem_cs     <= 1'b1;
            if (grant == logic'(OWN_ACC)) begin
                mem_rd_wr <= a_rd_wr;
                mem_mask  <= a_mask;
                mem_addr  <= a_addr;
                mem_wdata <= a_wdata;
            end else begin
                mem_rd_wr <= c_rd_wr;
                mem_mask  <= c_mask;
                mem_addr  <= c_addr;
                mem_wdata <= c_wdata;
            end
        end else if (finish) begin
            mem_cs  <= 1'b0;
            rdata_q <= tmo_hit ? DATA_W'(ERR_RDATA) : mem_rdata;
        end
    end

    assign c_valid = (state == RESP) && (owner_q == OWN_CPU);
    assign a_valid = (state == RESP) && (owner_q == OWN_ACC);
    assign c_rdata = c_valid ? rdata_q : '0;
    assign a_rdata = a_valid ? rdata_q : '0;
    assign owner   = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: vector table for contention/read/stray cases, hand sequences for the rest.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_cs, c_rd_wr, a_cs, a_rd_wr;
    logic [3:0]  c_mask, a_mask;
    logic [31:0] c_addr, c_wdata, a_addr, a_wdata;
    logic [31:0] c_rdata, a_rdata;
    logic        c_valid, c_err, a_valid, a_err;
    logic        mem_cs, mem_rd_wr, mem_valid;
    logic [3:0]  mem_mask;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        owner;

    int n_chk  = 0;
    int n_fail = 0;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .c_cs(c_cs), .c_rd_wr(c_rd_wr), .c_mask(c_mask), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_valid(c_valid), .c_err(c_err),
        .a_cs(a_cs), .a_rd_wr(a_rd_wr), .a_mask(a_mask), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_valid(a_valid), .a_err(a_err),
        .mem_cs(mem_cs), .mem_rd_wr(mem_rd_wr), .mem_mask(mem_mask), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .owner(owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        c_cs;
        logic        a_cs;
        logic        mv;
        logic [31:0] md;
        logic        e_mem_cs;
        logic [31:0] e_addr;
        logic        e_owner;
        logic        e_cv;
        logic        e_av;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vt[$];

    task automatic add_vec(input string n, input logic c, input logic a, input logic mv,
                           input logic [31:0] md, input logic e_cs, input logic [31:0] e_addr,
                           input logic e_own, input logic e_cv, input logic e_av,
                           input logic [31:0] e_rd);
        vec_t v;
        v.name = n; v.c_cs = c; v.a_cs = a; v.mv = mv; v.md = md;
        v.e_mem_cs = e_cs; v.e_addr = e_addr; v.e_owner = e_own;
        v.e_cv = e_cv; v.e_av = e_av; v.e_rd = e_rd;
        vt.push_back(v);
    endtask

    task automatic chk1(input string n, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", n, act, exp);
        end
    endtask

    task automatic chk32(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr_of [2];
        addr_of[0] = 32'h0000_0100;
        addr_of[1] = 32'h0000_0200;

        // Contention: both requesting, memory answers on the 2nd XFER cycle.
        for (int k = 0; k < 6; k++) begin
            logic o;
            o = k[0];
            add_vec($sformatf("cont%0d_grant", k), 1, 1, 0, 32'h0, 1, addr_of[o], o, 0, 0, 32'h0);
            add_vec($sformatf("cont%0d_xfer", k),  1, 1, 0, 32'h0, 1, addr_of[o], o, 0, 0, 32'h0);
            add_vec($sformatf("cont%0d_resp", k),  1, 1, 1, 32'hA000_0000 + k, 0, addr_of[o], o,
                    !o, o, 32'hA000_0000 + k);
            add_vec($sformatf("cont%0d_idle", k),  1, 1, 0, 32'h0, 0, addr_of[o], o, 0, 0, 32'h0);
        end
        // CPU read, then stray mem_valid in RESP and in IDLE.
        add_vec("rd_grant",    1, 0, 0, 32'h0,         1, 32'h100, 0, 0, 0, 32'h0);
        add_vec("rd_xfer",     1, 0, 0, 32'h0,         1, 32'h100, 0, 0, 0, 32'h0);
        add_vec("rd_resp",     1, 0, 1, 32'hCAFE_F00D, 0, 32'h100, 0, 1, 0, 32'hCAFE_F00D);
        add_vec("stray_resp",  0, 0, 1, 32'h1111_1111, 0, 32'h100, 0, 0, 0, 32'h0);
        add_vec("stray_idle",  0, 0, 1, 32'h2222_2222, 0, 32'h100, 0, 0, 0, 32'h0);
        add_vec("stray_after", 0, 0, 0, 32'h0,         0, 32'h100, 0, 0, 0, 32'h0);

        reset = 1'b1;
        c_cs = 0; c_rd_wr = 1; c_mask = 4'hF; c_addr = 32'h100; c_wdata = 32'h0C0C_0C0C;
        a_cs = 0; a_rd_wr = 1; a_mask = 4'hF; a_addr = 32'h200; a_wdata = 32'h0A0A_0A0A;
        mem_valid = 0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk1("rst_mem_cs", mem_cs, 0);
        chk1("rst_c_valid", c_valid, 0);
        chk1("rst_a_valid", a_valid, 0);
        chk1("rst_owner", owner, 0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_c_rdata", c_rdata, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            c_cs = vt[i].c_cs; a_cs = vt[i].a_cs;
            mem_valid = vt[i].mv; mem_rdata = vt[i].md;
            tick();
            chk1({vt[i].name, "_mem_cs"}, mem_cs, vt[i].e_mem_cs);
            chk32({vt[i].name, "_mem_addr"}, mem_addr, vt[i].e_addr);
            chk1({vt[i].name, "_owner"}, owner, vt[i].e_owner);
            chk1({vt[i].name, "_c_valid"}, c_valid, vt[i].e_cv);
            chk1({vt[i].name, "_a_valid"}, a_valid, vt[i].e_av);
            chk32({vt[i].name, "_c_rdata"}, c_rdata, vt[i].e_cv ? vt[i].e_rd : 32'h0);
            chk32({vt[i].name, "_a_rdata"}, a_rdata, vt[i].e_av ? vt[i].e_rd : 32'h0);
            chk1({vt[i].name, "_c_err"}, c_err, 0);
        end

        // Accelerator write; a CPU request raised mid-XFER must wait.
        @(negedge clk);
        mem_valid = 0;
        a_cs = 1; a_rd_wr = 0; a_mask = 4'b0011; a_wdata = 32'h1234_5678;
        tick();
        chk1("wr_grant_owner", owner, 1);
        for (int j = 0; j < 4; j++) begin
            if (j == 1) begin
                @(negedge clk);
                c_cs = 1;
                tick();
            end else if (j > 1) begin
                tick();
            end
            chk1($sformatf("wr_x%0d_mem_cs", j), mem_cs, 1);
            chk1($sformatf("wr_x%0d_rd_wr", j), mem_rd_wr, 0);
            chk32($sformatf("wr_x%0d_mask", j), {28'h0, mem_mask}, 32'h3);
            chk32($sformatf("wr_x%0d_wdata", j), mem_wdata, 32'h1234_5678);
            chk32($sformatf("wr_x%0d_addr", j), mem_addr, 32'h200);
            chk1($sformatf("wr_x%0d_c_valid", j), c_valid, 0);
        end
        @(negedge clk);
        mem_valid = 1; mem_rdata = 32'h5555_AAAA;
        tick();
        chk1("wr_resp_a_valid", a_valid, 1);
        chk1("wr_resp_a_err", a_err, 0);
        chk1("wr_resp_c_valid", c_valid, 0);
        chk32("wr_resp_a_rdata", a_rdata, 32'h5555_AAAA);
        chk1("wr_resp_mem_cs", mem_cs, 0);
        @(negedge clk);
        mem_valid = 0; a_cs = 0;
        tick();
        chk1("wr_idle_a_valid", a_valid, 0);
        chk1("wr_idle_mem_cs", mem_cs, 0);
        tick();
        chk1("late_c_owner", owner, 0);
        chk1("late_c_mem_cs", mem_cs, 1);
        chk32("late_c_addr", mem_addr, 32'h100);
        chk1("late_c_rd_wr", mem_rd_wr, 1);
        @(negedge clk);
        mem_valid = 1; mem_rdata = 32'h0000_0077;
        tick();
        chk1("late_c_valid", c_valid, 1);
        chk32("late_c_rdata", c_rdata, 32'h0000_0077);
        chk1("late_c_a_valid", a_valid, 0);
        @(negedge clk);
        mem_valid = 0; c_cs = 0;
        tick();
        chk1("late_c_done", c_valid, 0);

        // Reset in the middle of a CPU transfer.
        @(negedge clk);
        c_cs = 1;
        tick();
        chk1("mid_grant_mem_cs", mem_cs, 1);
        #2;
        reset = 1'b1;
        #1;
        chk1("mid_rst_mem_cs", mem_cs, 0);
        chk1("mid_rst_c_valid", c_valid, 0);
        chk1("mid_rst_a_valid", a_valid, 0);
        chk32("mid_rst_addr", mem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0; c_cs = 1; a_cs = 1;
        tick();
        chk1("post_rst_owner", owner, 0);
        chk32("post_rst_addr", mem_addr, 32'h100);

        // No completion: watchdog fires only in the timeout build.
        for (int j = 1; j <= 3; j++) begin
            tick();
            chk1($sformatf("tmo_wait%0d_mem_cs", j), mem_cs, 1);
            chk1($sformatf("tmo_wait%0d_c_valid", j), c_valid, 0);
        end
        tick();
`ifdef MEM_ARB_TIMEOUT_EN
        chk1("tmo_c_valid", c_valid, 1);
        chk1("tmo_c_err", c_err, 1);
        chk32("tmo_c_rdata", c_rdata, 32'hDEAD_BEEF);
        chk1("tmo_mem_cs", mem_cs, 0);
        @(negedge clk);
        c_cs = 0;
        tick();
        chk1("tmo_done_c_valid", c_valid, 0);
        chk1("tmo_done_c_err", c_err, 0);
`else
        begin
            int seen;
            seen = 0;
            chk1("hold_c_valid", c_valid, 0);
            chk1("hold_mem_cs", mem_cs, 1);
            repeat (20) begin
                tick();
                if (c_valid || !mem_cs) seen++;
            end
            chk32("hold_long_events", seen, 0);
        end
        @(negedge clk);
        mem_valid = 1; mem_rdata = 32'h0000_9999;
        tick();
        chk1("hold_end_c_valid", c_valid, 1);
        chk1("hold_end_c_err", c_err, 0);
        chk32("hold_end_c_rdata", c_rdata, 32'h0000_9999);
        @(negedge clk);
        mem_valid = 0; c_cs = 0;
        tick();
        chk1("hold_done_c_valid", c_valid, 0);
`endif
        // The accelerator, waiting throughout, is served next.
        tick();
        chk1("acc_after_owner", owner, 1);
        chk1("acc_after_mem_cs", mem_cs, 1);
        chk32("acc_after_addr", mem_addr, 32'h200);
        @(negedge clk);
        mem_valid = 1; mem_rdata = 32'hBBBB_0001;
        tick();
        chk1("acc_after_a_valid", a_valid, 1);
        chk1("acc_after_a_err", a_err, 0);
        chk32("acc_after_a_rdata", a_rdata, 32'hBBBB_0001);
        @(negedge clk);
        mem_valid = 0; a_cs = 0;
        tick();
        chk1("acc_after_done", a_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
